// File: rtl/ip_sel_switch_ctrl.sv
// ip_sel_switch_ctrl
// Sequences hand-over of the shared pad ring between NUM_IP selectable IP cores.
// The raw ip_sel pads are synchronised and debounced. On an accepted change the
// outgoing IP is drained (or timed out) and isolated. All IPs are then held in
// reset while the pad mux moves. Finally only the newly selected IP is released,
// and the pad-valid flag rises in that same cycle.
module ip_sel_switch_ctrl #(
  parameter int NUM_IP          = 6,
  parameter int SEL_W           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int DRAIN_CYCLES    = 256,
  parameter int RST_HOLD_CYCLES = 64
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic [SEL_W-1:0]  ip_sel_i,
  input  logic [NUM_IP-1:0] ip_idle_i,
  output logic [NUM_IP-1:0] ip_rst_n_o,
  output logic [SEL_W-1:0]  pad_sel_o,
  output logic              pad_sel_vld_o,
  output logic              busy_o,
  output logic              sel_err_o
);

  localparam int STAB_W    = $clog2(STABLE_CYCLES + 1);
  localparam int PHASE_MAX = (DRAIN_CYCLES > RST_HOLD_CYCLES) ? DRAIN_CYCLES : RST_HOLD_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [STAB_W-1:0]  STAB_LIMIT = STAB_W'(STABLE_CYCLES);
  localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(DRAIN_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(RST_HOLD_CYCLES - 1);
  localparam logic [SEL_W:0]     NUM_IP_EXT = (SEL_W + 1)'(NUM_IP);
  localparam logic [NUM_IP-1:0]  IP_ONE     = {{(NUM_IP - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    ACTIVE  = 3'd1,
    DRAIN   = 3'd2,
    ISOLATE = 3'd3,
    HOLD    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  // Synchroniser chain; index 0 samples the pads, the last stage is sel_s.
  logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_reg;
  logic [SEL_W-1:0]                  sel_s;
  logic [SEL_W-1:0]                  sel_pre;

  logic [STAB_W-1:0]  stab_cnt_reg;
  logic [STAB_W-1:0]  stab_cnt_next;
  logic               sel_stable;
  logic               sel_legal;

  state_t             state_reg;
  state_t             state_next;
  logic [PHASE_W-1:0] phase_cnt_reg;
  logic [PHASE_W-1:0] phase_cnt_next;
  logic [SEL_W-1:0]   tgt_reg;
  logic [SEL_W-1:0]   tgt_next;
  logic [SEL_W-1:0]   pad_sel_reg;
  logic [SEL_W-1:0]   pad_sel_next;
  logic               sel_err_reg;

  logic [NUM_IP-1:0]  ip_rst_n;
  logic               pad_vld;
  logic               busy;

  assign sel_s     = sync_reg[SYNC_STAGES-1];
  assign sel_pre   = sync_reg[SYNC_STAGES-2];
  assign sel_legal = ({1'b0, sel_s} < NUM_IP_EXT);
  assign sel_stable = (stab_cnt_reg == STAB_LIMIT);

  // Shift the raw pad value through the synchroniser flops.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ip_sel_i};
    end
  end

  // Stability count: zeroed in the cycle sel_s takes a new value, otherwise saturating increment.
  always_comb begin
    stab_cnt_next = stab_cnt_reg;
    if (sel_pre != sel_s) begin
      stab_cnt_next = '0;
    end else if (stab_cnt_reg != STAB_LIMIT) begin
      stab_cnt_next = stab_cnt_reg + STAB_W'(1);
    end
  end

  // Stability counter register.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stab_cnt_reg <= '0;
    end else begin
      stab_cnt_reg <= stab_cnt_next;
    end
  end

  // Sticky illegal-select flag, refreshed by every stable value.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_err_reg <= 1'b0;
    end else if (sel_stable) begin
      sel_err_reg <= ~sel_legal;
    end
  end

  // FSM state, phase counter, target and pad mux select registers.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= BOOT;
      phase_cnt_reg <= '0;
      tgt_reg       <= '0;
      pad_sel_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      tgt_reg       <= tgt_next;
      pad_sel_reg   <= pad_sel_next;
    end
  end

  // Next-state and Moore outputs; the pad mux only moves on HOLD entry, while valid is low.
  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    tgt_next       = tgt_reg;
    pad_sel_next   = pad_sel_reg;
    ip_rst_n       = '0;
    pad_vld        = 1'b0;
    busy           = 1'b1;
    case (state_reg)
      BOOT: begin
        if (sel_stable && sel_legal) begin
          tgt_next       = sel_s;
          pad_sel_next   = sel_s;
          phase_cnt_next = '0;
          state_next     = HOLD;
        end
      end
      ACTIVE: begin
        ip_rst_n = IP_ONE << pad_sel_reg;
        pad_vld  = 1'b1;
        busy     = 1'b0;
        if (sel_stable && sel_legal && (sel_s != pad_sel_reg)) begin
          tgt_next       = sel_s;
          phase_cnt_next = '0;
          state_next     = DRAIN;
        end
      end
      DRAIN: begin
        ip_rst_n = IP_ONE << pad_sel_reg;
        pad_vld  = 1'b1;
        if (ip_idle_i[pad_sel_reg] || (phase_cnt_reg == DRAIN_LAST)) begin
          state_next = ISOLATE;
        end else begin
          phase_cnt_next = phase_cnt_reg + PHASE_W'(1);
        end
      end
      ISOLATE: begin
        pad_sel_next   = tgt_reg;
        phase_cnt_next = '0;
        state_next     = HOLD;
      end
      HOLD: begin
        if (phase_cnt_reg == HOLD_LAST) begin
          state_next = RELEASE;
        end else begin
          phase_cnt_next = phase_cnt_reg + PHASE_W'(1);
        end
      end
      RELEASE: begin
        ip_rst_n   = IP_ONE << pad_sel_reg;
        pad_vld    = 1'b1;
        state_next = ACTIVE;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign ip_rst_n_o    = ip_rst_n;
  assign pad_sel_o     = pad_sel_reg;
  assign pad_sel_vld_o = pad_vld;
  assign busy_o        = busy;
  assign sel_err_o     = sel_err_reg;

endmodule

// File: tb/tb_ip_sel_switch_ctrl.sv
// Testbench for ip_sel_switch_ctrl: table-driven vectors, exact-timing corner
// sequences, and randomized select traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_ip_sel_switch_ctrl;

  localparam int NUM_IP = 6;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SEL_W-1:0]  ip_sel = 3'd1;
  logic [NUM_IP-1:0] ip_idle = '0;
  logic [NUM_IP-1:0] ip_rst_n;
  logic [SEL_W-1:0]  pad_sel;
  logic              pad_vld;
  logic              busy;
  logic              sel_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ip_sel_switch_ctrl #(
    .NUM_IP          (NUM_IP),
    .SEL_W           (SEL_W),
    .SYNC_STAGES     (2),
    .STABLE_CYCLES   (8),
    .DRAIN_CYCLES    (16),
    .RST_HOLD_CYCLES (4)
  ) dut (
    .sys_clk_i     (clk),
    .rst_n_i       (rst_n),
    .ip_sel_i      (ip_sel),
    .ip_idle_i     (ip_idle),
    .ip_rst_n_o    (ip_rst_n),
    .pad_sel_o     (pad_sel),
    .pad_sel_vld_o (pad_vld),
    .busy_o        (busy),
    .sel_err_o     (sel_err)
  );

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [NUM_IP-1:0] idle;
    int                cycles;
    logic [NUM_IP-1:0] rst;
    logic [SEL_W-1:0]  pad;
    logic              vld;
    logic              bsy;
    logic              err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_all(input string name, input logic [NUM_IP-1:0] rst, input logic [SEL_W-1:0] pad,
                            input logic vld, input logic bsy, input logic err);
    check({name, ".ip_rst_n"}, 32'(ip_rst_n), 32'(rst));
    check({name, ".pad_sel"},  32'(pad_sel),  32'(pad));
    check({name, ".vld"},      32'(pad_vld),  32'(vld));
    check({name, ".busy"},     32'(busy),     32'(bsy));
    check({name, ".sel_err"},  32'(sel_err),  32'(err));
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_IP-1:0] onehot(input int i);
    logic [NUM_IP-1:0] v;
    v = 1;
    return v << i;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEL_W-1:0]  s;
    logic [SEL_W-1:0]  prev_raw;
    logic [SEL_W-1:0]  prev_pad;
    logic              prev_vld;
    int                len;
    int                viol;
    int                cur;
    logic              err_m;

    vecs[0] = '{3'd1, 6'h00,  5, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 6'h00,  5, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd1, 6'h00, 20, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'd7, 6'h00, 20, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'd2, 6'h3F, 20, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'd6, 6'h3F, 20, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{3'd5, 6'h3F, 20, 6'b100000, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{3'd5, 6'h00,  5, 6'b100000, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3'd1, 6'h3F, 20, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0};

    // Boot with sel=1 held: accepted after 2 sync + 8 stable cycles, then 4 HOLD cycles.
    #3;
    expect_all("reset", 6'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    expect_all("boot.wait", 6'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("boot.hold", 6'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step(3);
    expect_all("boot.hold_end", 6'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("boot.release", 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("boot.active", 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0);
    $display("boot: pad_sel=%0d ip_rst_n=%b vld=%0d busy=%0d", pad_sel, ip_rst_n, pad_vld, busy);

    // Table: glitch, illegal select, legal switches, same-value reselect.
    for (int i = 0; i < 9; i++) begin
      ip_sel  = vecs[i].sel;
      ip_idle = vecs[i].idle;
      step(vecs[i].cycles);
      expect_all($sformatf("row%0d", i), vecs[i].rst, vecs[i].pad, vecs[i].vld, vecs[i].bsy, vecs[i].err);
      $display("row%0d: sel=%0d idle=%b -> pad_sel=%0d ip_rst_n=%b vld=%0d busy=%0d err=%0d",
               i, vecs[i].sel, vecs[i].idle, pad_sel, ip_rst_n, pad_vld, busy, sel_err);
    end

    // Switch 1->3 with the outgoing IP idle: one DRAIN cycle, ISOLATE, 4 HOLD, RELEASE.
    ip_sel  = 3'd3;
    ip_idle = 6'b000010;
    step(10);
    expect_all("sw.pre", 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_all("sw.drain", 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("sw.isolate", 6'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("sw.hold", 6'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    step(3);
    expect_all("sw.hold_end", 6'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("sw.release", 6'b001000, 3'd3, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("sw.active", 6'b001000, 3'd3, 1'b1, 1'b0, 1'b0);
    $display("switch 1->3: pad_sel=%0d ip_rst_n=%b", pad_sel, ip_rst_n);

    // Switch 3->0 with no idle: DRAIN lasts exactly 16 cycles before ISOLATE.
    ip_sel  = 3'd0;
    ip_idle = 6'b0;
    step(11);
    expect_all("to.drain_entry", 6'b001000, 3'd3, 1'b1, 1'b1, 1'b0);
    step(15);
    expect_all("to.drain_last", 6'b001000, 3'd3, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("to.isolate", 6'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("to.hold", 6'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(4);
    expect_all("to.release", 6'b000001, 3'd0, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("to.active", 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);
    $display("timeout 3->0: pad_sel=%0d ip_rst_n=%b", pad_sel, ip_rst_n);

    // Reset during HOLD of a 0->4 switch, then reboot on the held sel=4.
    ip_sel  = 3'd4;
    ip_idle = 6'h3F;
    step(13);
    expect_all("rh.hold", 6'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("rh.hold2", 6'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("rh.reset", 6'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    expect_all("rh.boot_wait", 6'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_all("rh.boot_hold", 6'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    step(4);
    expect_all("rh.release", 6'b010000, 3'd4, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_all("rh.active", 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0);
    $display("reset mid-hold: pad_sel=%0d ip_rst_n=%b", pad_sel, ip_rst_n);

    // Randomized segments: each raw value differs from the previous one. Segments of
    // 1..7 cycles never debounce; 40-cycle segments always complete any switch.
    prev_raw = 3'd4;
    cur      = 4;
    err_m    = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      do s = SEL_W'($urandom_range(0, 7)); while (s == prev_raw);
      len = ($urandom_range(0, 2) == 0) ? 40 : int'($urandom_range(1, 7));
      ip_sel  = s;
      ip_idle = NUM_IP'($urandom);
      viol    = 0;
      for (int c = 0; c < len; c++) begin
        prev_pad = pad_sel;
        prev_vld = pad_vld;
        step(1);
        if ((pad_sel != prev_pad) && (prev_vld || pad_vld)) viol++;
        if (!pad_vld && (ip_rst_n != '0)) viol++;
        if (pad_vld && (ip_rst_n != onehot(int'(pad_sel)))) viol++;
        if (!busy && !pad_vld) viol++;
        ip_idle = NUM_IP'($urandom);
      end
      if (len == 40) begin
        if (int'(s) < NUM_IP) begin
          cur   = int'(s);
          err_m = 1'b0;
        end else begin
          err_m = 1'b1;
        end
      end
      prev_raw = s;
      check($sformatf("rnd%0d.ordering", seg), 32'(viol), 32'd0);
      expect_all($sformatf("rnd%0d", seg), onehot(cur), SEL_W'(cur), 1'b1, 1'b0, err_m);
      $display("rnd%0d: sel=%0d len=%0d -> pad_sel=%0d ip_rst_n=%b err=%0d (model ip=%0d err=%0d)",
               seg, s, len, pad_sel, ip_rst_n, sel_err, cur, err_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
